systolic_feeder: RTL

Transmit-side sequencer for the `systolic` FP-INT MAC array. It buffers a job of activation/weight vectors from an upstream load port. On `start` it streams each vector into the array: one activation per row is held stable while the column weights are shifted out bit-serially, MSB-first, over `precision` cycles. It then waits for the array's `done` and reports job completion.

---
 rtl/systolic_pkg.sv | 9 +
 rtl/w_serializer.sv | 48 ++++
 rtl/systolic_feeder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feeder and its column serializers.
package systolic_pkg;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   localparam int PREC_W       = 4;
   localparam int MAX_PREC_DEF = 8;

endpackage

// File: rtl/w_serializer.sv
// Bit-serial weight shifter for one array column: emits bits P-1 down to 0, MSB first.
module w_serializer
   import systolic_pkg::*;
#(
   parameter int MAX_PREC = MAX_PREC_DEF
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                shift,
   input  logic                clear,
   input  logic [MAX_PREC-1:0] word,
   input  logic [PREC_W-1:0]   prec,
   output logic                bit_out,
   output logic                last
);

   logic [MAX_PREC-1:0] word_q;
   logic [PREC_W-1:0]   idx;
   logic [PREC_W-1:0]   load_idx;
   logic [PREC_W-1:0]   shift_idx;
   logic                load_bit;
   logic                shift_bit;

   assign load_idx  = prec - PREC_W'(1);
   assign shift_idx = idx - PREC_W'(1);
   // Bit selection through a one-hot mask keeps every word bit in use for any P.
   assign load_bit  = |(word & (MAX_PREC'(1) << load_idx));
   assign shift_bit = |(word_q & (MAX_PREC'(1) << shift_idx));
   assign last      = (idx == '0);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         word_q  <= '0;
         idx     <= '0;
         bit_out <= 1'b0;
      end else if (load) begin
         word_q  <= word;
         idx     <= load_idx;
         bit_out <= load_bit;
      end else if (shift) begin
         idx     <= shift_idx;
         bit_out <= shift_bit;
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// Job buffer and sequencer that streams activations and bit-serial weights into the
// systolic MAC array, then waits for the array to report done.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int ACT_WIDTH = 16,
   parameter int N         = 2,
   parameter int MAX_PREC  = MAX_PREC_DEF,
   parameter int DEPTH     = 16
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ld_valid,
   output logic                   ld_ready,
   input  logic [N*ACT_WIDTH-1:0] ld_act,
   input  logic [N*MAX_PREC-1:0]  ld_w,
   input  logic                   start,
   input  logic [PREC_W-1:0]      precision,
   input  logic                   array_done,
   output logic                   active,
   output logic [N*ACT_WIDTH-1:0] act_out,
   output logic [N-1:0]           w_out,
   output logic [PREC_W-1:0]      prec_out,
   output logic                   busy,
   output logic                   job_done,
   output logic                   err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [N*ACT_WIDTH-1:0] act_mem [DEPTH];
   logic [N*MAX_PREC-1:0]  w_mem   [DEPTH];

   state_t                 state, state_d;
   logic [CW-1:0]          count, count_d, count_ld;
   logic [AW-1:0]          wptr, rptr;
   logic                   load_beat, prec_ok;
   logic                   start_ok, start_bad, entry_end, job_end, drain_end;
   logic                   ser_load, ser_shift, ser_clear;
   logic [PREC_W-1:0]      ser_prec;
   logic [N-1:0]           col_last;
   logic [N*ACT_WIDTH-1:0] rd_act;
   logic [N*MAX_PREC-1:0]  rd_w;

   assign load_beat = ld_valid && ld_ready;
   assign count_ld  = count + CW'(load_beat);
   assign prec_ok   = (precision != '0) && (int'(precision) <= MAX_PREC);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // A start that coincides with a load beat is judged on the count including that beat.
   always_comb begin
      state_d   = state;
      start_ok  = 1'b0;
      start_bad = 1'b0;
      entry_end = 1'b0;
      job_end   = 1'b0;
      drain_end = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (prec_ok && (count_ld != '0)) begin
                  start_ok = 1'b1;
                  state_d  = STREAM;
               end else begin
                  start_bad = 1'b1;
               end
            end
         end
         STREAM: begin
            if (&col_last) begin
               entry_end = 1'b1;
               if ({1'b0, rptr} == count - CW'(1)) begin
                  job_end = 1'b1;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (array_done) begin
               drain_end = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The first entry is forwarded straight from the load port when it arrives with start.
   always_comb begin
      ser_load  = start_ok || (entry_end && !job_end);
      ser_shift = (state == STREAM) && !entry_end;
      ser_clear = job_end;
      ser_prec  = start_ok ? precision : prec_out;
      count_d   = drain_end ? '0 : count_ld;
      if (state == IDLE) begin
         rd_act = (count == '0) ? ld_act : act_mem[0];
         rd_w   = (count == '0) ? ld_w   : w_mem[0];
      end else begin
         rd_act = act_mem[rptr + AW'(1)];
         rd_w   = w_mem[rptr + AW'(1)];
      end
   end

   always_ff @(posedge clk) begin
      if (load_beat) begin
         act_mem[wptr] <= ld_act;
         w_mem[wptr]   <= ld_w;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         wptr     <= '0;
         rptr     <= '0;
         active   <= 1'b0;
         act_out  <= '0;
         prec_out <= '0;
         busy     <= 1'b0;
         job_done <= 1'b0;
         err      <= 1'b0;
         ld_ready <= 1'b1;
      end else begin
         count <= count_d;
         if (load_beat) begin
            wptr <= wptr + AW'(1);
         end else if (drain_end) begin
            wptr <= '0;
         end
         if (start_ok || drain_end) begin
            rptr <= '0;
         end else if (entry_end && !job_end) begin
            rptr <= rptr + AW'(1);
         end
         if (start_ok) begin
            prec_out <= precision;
         end
         if (ser_load) begin
            act_out <= rd_act;
         end else if (state_d != STREAM) begin
            act_out <= '0;
         end
         active   <= (state_d == STREAM);
         busy     <= (state_d != IDLE);
         job_done <= drain_end;
         err      <= start_bad;
         ld_ready <= (state_d == IDLE) && (count_d != CW'(DEPTH));
      end
   end

   for (genvar c = 0; c < N; c++) begin : g_col
      w_serializer #(.MAX_PREC(MAX_PREC)) u_ser (
         .clk     (clk),
         .rst     (rst),
         .load    (ser_load),
         .shift   (ser_shift),
         .clear   (ser_clear),
         .word    (rd_w[c*MAX_PREC +: MAX_PREC]),
         .prec    (ser_prec),
         .bit_out (w_out[c]),
         .last    (col_last[c])
      );
   end

endmodule
